// File: rtl/camera_capture_downsampler.sv
// camera_capture_downsampler: samples an 8-bit camera bus, pairs bytes into
// RGB565 pixels, reduces them to RGB323 and emits one frame-buffer write per
// pixel with X/Y coordinates. VSYNC/HREF framing is tracked from registered
// copies of the sync lines; oversize lines/frames set a per-frame OVERFLOW.
// Optional build macro COLOR_BAR_EN replaces camera pixel data with three
// fixed horizontal colour bars (red/green/blue, 48 rows each).
`timescale 1ns/1ps

module camera_capture_downsampler #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int HI_FIRST      = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] CAM_DATA,
  input  logic       CAM_HREF,
  input  logic       CAM_VSYNC,
  output logic [7:0] PIXEL_OUT,
  output logic       WRITE_EN,
  output logic [7:0] WRITE_X,
  output logic [7:0] WRITE_Y,
  output logic       FRAME_DONE,
  output logic [7:0] LINES_CAPTURED,
  output logic       OVERFLOW
);

  localparam logic [7:0] WIDTH8  = SCREEN_WIDTH[7:0];
  localparam logic [7:0] HEIGHT8 = SCREEN_HEIGHT[7:0];

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    BYTE_A     = 2'd2,
    BYTE_B     = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       vsync_q, href_q;
  logic [7:0] first_q, first_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] line_cnt_q, line_cnt_d;
  logic [7:0] pixel_q, pixel_d;
  logic       we_q, we_d;
  logic [7:0] wx_q, wx_d;
  logic [7:0] wy_q, wy_d;
  logic       fd_q, fd_d;
  logic [7:0] lines_q, lines_d;
  logic       ovf_q, ovf_d;

  logic       vsync_rise, vsync_fall, href_fall;
  logic       line_end;
  logic [7:0] pix_val;

  assign vsync_rise = CAM_VSYNC & ~vsync_q;
  assign vsync_fall = ~CAM_VSYNC & vsync_q;
  assign href_fall  = href_q & ~CAM_HREF;

`ifdef COLOR_BAR_EN
  // Bar colour depends only on the row being written; camera data is ignored.
  always_comb begin
    if (y_q < 8'd48)      pix_val = 8'hE0;
    else if (y_q < 8'd96) pix_val = 8'h18;
    else                  pix_val = 8'h07;
  end
`else
  logic [7:0] hi_byte, lo_byte;
  // The current bus byte completes the pair; HI_FIRST says which half it is.
  always_comb begin
    hi_byte = (HI_FIRST != 0) ? first_q  : CAM_DATA;
    lo_byte = (HI_FIRST != 0) ? CAM_DATA : first_q;
    pix_val = {hi_byte[7:5], hi_byte[2:1], lo_byte[4:2]};
  end
`endif

  // Framing FSM, pixel pairing and write/status generation.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    x_d        = x_q;
    y_d        = y_q;
    line_cnt_d = line_cnt_q;
    pixel_d    = pixel_q;
    we_d       = 1'b0;
    wx_d       = wx_q;
    wy_d       = wy_q;
    fd_d       = 1'b0;
    lines_d    = lines_q;
    ovf_d      = ovf_q;
    line_end   = 1'b0;

    if (state_q == WAIT_FRAME) begin
      if (vsync_fall) begin
        state_d    = WAIT_LINE;
        x_d        = 8'd0;
        y_d        = 8'd0;
        line_cnt_d = 8'd0;
        ovf_d      = 1'b0;
      end
    end else if (vsync_rise) begin
      // Frame end beats any line activity; a partial line is not counted.
      fd_d    = 1'b1;
      lines_d = line_cnt_q;
      state_d = WAIT_FRAME;
    end else begin
      case (state_q)
        WAIT_LINE: begin
          if (CAM_HREF) begin
            first_d = CAM_DATA;
            state_d = BYTE_B;
          end
        end
        BYTE_A: begin
          if (CAM_HREF) begin
            first_d = CAM_DATA;
            state_d = BYTE_B;
          end else if (href_fall) begin
            line_end = 1'b1;
          end
        end
        BYTE_B: begin
          if (CAM_HREF) begin
            state_d = BYTE_A;
            if ((x_q < WIDTH8) && (y_q < HEIGHT8)) begin
              we_d    = 1'b1;
              pixel_d = pix_val;
              wx_d    = x_q;
              wy_d    = y_q;
              x_d     = x_q + 8'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (href_fall) begin
            // Half pixel in first_q is simply abandoned.
            line_end = 1'b1;
          end
        end
        default: state_d = WAIT_FRAME;
      endcase
    end

    if (line_end) begin
      state_d = WAIT_LINE;
      x_d     = 8'd0;
      if (y_q < HEIGHT8)        y_d        = y_q + 8'd1;
      if (line_cnt_q != 8'hFF)  line_cnt_d = line_cnt_q + 8'd1;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= WAIT_FRAME;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      first_q    <= 8'd0;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      line_cnt_q <= 8'd0;
      pixel_q    <= 8'd0;
      we_q       <= 1'b0;
      wx_q       <= 8'd0;
      wy_q       <= 8'd0;
      fd_q       <= 1'b0;
      lines_q    <= 8'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= CAM_VSYNC;
      href_q     <= CAM_HREF;
      first_q    <= first_d;
      x_q        <= x_d;
      y_q        <= y_d;
      line_cnt_q <= line_cnt_d;
      pixel_q    <= pixel_d;
      we_q       <= we_d;
      wx_q       <= wx_d;
      wy_q       <= wy_d;
      fd_q       <= fd_d;
      lines_q    <= lines_d;
      ovf_q      <= ovf_d;
    end
  end

  assign PIXEL_OUT      = pixel_q;
  assign WRITE_EN       = we_q;
  assign WRITE_X        = wx_q;
  assign WRITE_Y        = wy_q;
  assign FRAME_DONE     = fd_q;
  assign LINES_CAPTURED = lines_q;
  assign OVERFLOW       = ovf_q;

endmodule

// File: tb/tb_camera_capture_downsampler.sv
// Directed bench for camera_capture_downsampler: expected writes are queued as
// bytes are driven and checked against each WRITE_EN strobe.
`timescale 1ns/1ps

module tb_camera_capture_downsampler;

  localparam int W = 176;
  localparam int H = 144;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] CAM_DATA = 8'd0;
  logic       CAM_HREF = 1'b0;
  logic       CAM_VSYNC = 1'b0;
  logic [7:0] PIXEL_OUT;
  logic       WRITE_EN;
  logic [7:0] WRITE_X;
  logic [7:0] WRITE_Y;
  logic       FRAME_DONE;
  logic [7:0] LINES_CAPTURED;
  logic       OVERFLOW;

  camera_capture_downsampler dut (
    .CLK(CLK), .RST_N(RST_N), .CAM_DATA(CAM_DATA), .CAM_HREF(CAM_HREF),
    .CAM_VSYNC(CAM_VSYNC), .PIXEL_OUT(PIXEL_OUT), .WRITE_EN(WRITE_EN),
    .WRITE_X(WRITE_X), .WRITE_Y(WRITE_Y), .FRAME_DONE(FRAME_DONE),
    .LINES_CAPTURED(LINES_CAPTURED), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int nwrites = 0;
  int exp_writes = 0;
  int fd_count = 0;
  int m_y = 0;
  logic [23:0] sb[$];
  logic [23:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int y, input logic [7:0] hi, input logic [7:0] lo);
`ifdef COLOR_BAR_EN
    if (y < 48)      return 8'hE0;
    else if (y < 96) return 8'h18;
    else             return 8'h07;
`else
    return {hi[7:5], hi[2:1], lo[4:2]};
`endif
  endfunction

  // Scoreboard consumer: every strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (WRITE_EN) begin
      nwrites++;
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_write: got x=%0d y=%0d pix=%0h expected no write", WRITE_X, WRITE_Y, PIXEL_OUT);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("pixel", {24'd0, PIXEL_OUT}, {24'd0, mon_e[23:16]});
        check("write_x", {24'd0, WRITE_X}, {24'd0, mon_e[15:8]});
        check("write_y", {24'd0, WRITE_Y}, {24'd0, mon_e[7:0]});
      end
    end
    if (FRAME_DONE) fd_count++;
  end

  // Global time bound so a stuck run still reports.
  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout expected finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_line(input int nbytes, input bit rnd, input logic [7:0] b0,
                            input logic [7:0] b1, input bit close);
    logic [7:0] prev, b;
    prev = 8'd0;
    for (int i = 0; i < nbytes; i++) begin
      b = rnd ? 8'($urandom) : (((i % 2) == 0) ? b0 : b1);
      @(negedge CLK);
      CAM_DATA = b;
      CAM_HREF = 1'b1;
      if ((i % 2) == 1 && (i / 2) < W && m_y < H) begin
        sb.push_back({exp_pix(m_y, prev, b), 8'(i / 2), 8'(m_y)});
        exp_writes++;
      end
      prev = b;
    end
    if (close) begin
      @(negedge CLK);
      CAM_HREF = 1'b0;
      CAM_DATA = 8'd0;
      @(negedge CLK);
      if (m_y < H) m_y++;
    end
  endtask

  task automatic start_frame();
    @(negedge CLK);
    CAM_VSYNC = 1'b1;
    repeat (2) @(negedge CLK);
    CAM_VSYNC = 1'b0;
    m_y = 0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic end_frame(input string tag, input int exp_lines, input bit exp_ovf);
    int fd0;
    fd0 = fd_count;
    @(negedge CLK);
    CAM_VSYNC = 1'b1;
    repeat (3) @(negedge CLK);
    check({tag, "_frame_done"}, fd_count - fd0, 1);
    check({tag, "_lines"}, {24'd0, LINES_CAPTURED}, exp_lines);
    check({tag, "_overflow"}, {31'd0, OVERFLOW}, {31'd0, exp_ovf});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel"}, {24'd0, PIXEL_OUT}, 0);
    check({tag, "_we"}, {31'd0, WRITE_EN}, 0);
    check({tag, "_x"}, {24'd0, WRITE_X}, 0);
    check({tag, "_y"}, {24'd0, WRITE_Y}, 0);
    check({tag, "_fd"}, {31'd0, FRAME_DONE}, 0);
    check({tag, "_lines"}, {24'd0, LINES_CAPTURED}, 0);
    check({tag, "_ovf"}, {31'd0, OVERFLOW}, 0);
  endtask

  initial begin
    int fd0;
    // Reset state
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // Single pixel, long line, then a short line to show X restarts
    start_frame();
    drive_line(2, 1'b0, 8'hF8, 8'h1F, 1'b1);
    check("single_ovf", {31'd0, OVERFLOW}, 0);
    drive_line(356, 1'b1, 8'h00, 8'h00, 1'b1);
    check("long_ovf", {31'd0, OVERFLOW}, 1);
    drive_line(2, 1'b0, 8'h12, 8'h34, 1'b1);
    end_frame("f1", 3, 1'b1);

    // Odd line drops its trailing byte; VSYNC during HREF ends frame uncounted
    start_frame();
    check("ovf_cleared", {31'd0, OVERFLOW}, 0);
    drive_line(3, 1'b0, 8'hA5, 8'h5A, 1'b1);
    drive_line(2, 1'b0, 8'h0F, 8'hF0, 1'b1);
    check("odd_ovf", {31'd0, OVERFLOW}, 0);
    drive_line(3, 1'b0, 8'hC3, 8'h3C, 1'b0);
    fd0 = fd_count;
    @(negedge CLK);
    CAM_DATA = 8'h77;
    CAM_VSYNC = 1'b1;
    @(negedge CLK);
    CAM_HREF = 1'b0;
    repeat (2) @(negedge CLK);
    check("vs_href_frame_done", fd_count - fd0, 1);
    check("vs_href_lines", {24'd0, LINES_CAPTURED}, 2);
    check("vs_href_ovf", {31'd0, OVERFLOW}, 0);

    // Full frame, exact size
    start_frame();
    for (int l = 0; l < H; l++) drive_line(352, 1'b1, 8'h00, 8'h00, 1'b1);
    end_frame("full", H, 1'b0);

    // One line too many
    start_frame();
    for (int l = 0; l < H + 1; l++) drive_line(4, 1'b1, 8'h00, 8'h00, 1'b1);
    end_frame("tall", H + 1, 1'b1);

    // Reset in the middle of a line, then resume
    start_frame();
    drive_line(3, 1'b0, 8'h81, 8'h42, 1'b0);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge CLK);
    CAM_HREF = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    start_frame();
    drive_line(2, 1'b0, 8'h66, 8'h99, 1'b1);
    drive_line(2, 1'b0, 8'hFF, 8'hFF, 1'b1);
    end_frame("post_reset", 2, 1'b0);

    repeat (4) @(negedge CLK);
    check("sb_drained", sb.size(), 0);
    check("write_count", nwrites, exp_writes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
